// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Sequences the member resets of one clock group.
//
// Power-on: while `reset` is high every member reset is held asserted. Once
// `reset` falls, its deassertion is synchronized through a SYNC_STAGES-deep
// flop chain. All members then stay in reset for HOLD_CYCLES edges and are
// released one at a time, lowest index first, GAP_CYCLES edges apart. The
// block then idles.
//
// Software: in IDLE a request carries a mask. Only the masked members are put
// back into reset and run through the same hold/stagger release. The sequence
// ends with a response handshake. An all-zero mask skips straight to the
// response.
//
// Ports
//   clock            in   sole clock, every register on the rising edge
//   reset            in   asynchronous, active-high reset
//   io_req_valid     in   software reset request valid
//   io_req_ready     out  high only in IDLE; request taken on valid&ready
//   io_req_bits_mask in   [NUM_MEMBERS] bit i set = reset member i
//   io_resp_valid    out  sequence-complete response, held until taken
//   io_resp_ready    in   response consumed on valid&ready
//   io_member_reset  out  [NUM_MEMBERS] registered active-high member resets
//   io_busy          out  high in every state except IDLE
//
// Parameters
//   SYNC_STAGES  reset-deassertion synchronizer depth (>= 2)
//   NUM_MEMBERS  number of member resets
//   HOLD_CYCLES  edges all targeted resets stay asserted (>= 1)
//   GAP_CYCLES   edges between successive member releases (>= 1)
// -----------------------------------------------------------------------------
module reset_sequencer #(
    parameter int SYNC_STAGES = 3,
    parameter int NUM_MEMBERS = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   io_req_valid,
    output logic                   io_req_ready,
    input  logic [NUM_MEMBERS-1:0] io_req_bits_mask,
    output logic                   io_resp_valid,
    input  logic                   io_resp_ready,
    output logic [NUM_MEMBERS-1:0] io_member_reset,
    output logic                   io_busy
);

    // -------------------------------------------------------------------------
    // Counter sizing
    // -------------------------------------------------------------------------
    // One counter is shared by HOLD and RELEASE. It is sized for the larger
    // of the two intervals and is cleared on every state entry.
    localparam int MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

    // -------------------------------------------------------------------------
    // FSM encoding
    // -------------------------------------------------------------------------
    localparam logic [2:0] ST_SYNC    = 3'd0;
    localparam logic [2:0] ST_HOLD    = 3'd1;
    localparam logic [2:0] ST_RELEASE = 3'd2;
    localparam logic [2:0] ST_RESP    = 3'd3;
    localparam logic [2:0] ST_IDLE    = 3'd4;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_chain_reg;
    logic [2:0]             state_reg,        state_next;
    logic [CNT_W-1:0]       cnt_reg,          cnt_next;
    logic [NUM_MEMBERS-1:0] mask_reg,         mask_next;
    logic                   sw_seq_reg,       sw_seq_next;
    logic [NUM_MEMBERS-1:0] member_reset_reg, member_reset_next;
    logic                   req_ready_reg,    req_ready_next;
    logic                   resp_valid_reg,   resp_valid_next;
    logic                   busy_reg,         busy_next;

    // -------------------------------------------------------------------------
    // Reset-deassertion synchronizer
    // -------------------------------------------------------------------------
    // The chain is set asynchronously and then shifts in zeros. Its last stage
    // reads 0 only after SYNC_STAGES clean edges following the fall of reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_chain_reg <= {SYNC_STAGES{1'b1}};
        end else begin
            sync_chain_reg <= {sync_chain_reg[SYNC_STAGES-2:0], 1'b0};
        end
    end

    // -------------------------------------------------------------------------
    // Next member to release
    // -------------------------------------------------------------------------
    // The power-on sequence targets every member. A software sequence targets
    // only the latched mask. "remaining" holds the targeted members that are
    // still in reset. Its lowest set bit is the one released next. Picking
    // that bit directly skips untargeted indices at no cycle cost.
    logic [NUM_MEMBERS-1:0] target;
    logic [NUM_MEMBERS-1:0] remaining;
    logic [NUM_MEMBERS-1:0] lower_any;
    logic [NUM_MEMBERS-1:0] release_onehot;
    logic                   last_release;

    assign target    = sw_seq_reg ? mask_reg : {NUM_MEMBERS{1'b1}};
    assign remaining = member_reset_reg & target;

    // lower_any[i] is set when any remaining bit lies below index i.
    assign lower_any[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_MEMBERS; gi++) begin : g_lower
            assign lower_any[gi] = lower_any[gi-1] | remaining[gi-1];
        end
        for (gi = 0; gi < NUM_MEMBERS; gi++) begin : g_pick
            assign release_onehot[gi] = remaining[gi] & ~lower_any[gi];
        end
    endgenerate

    // Releasing release_onehot empties the remaining set.
    assign last_release = ~|(remaining & ~release_onehot);

    // Saturating increment. The counter is always cleared before it could
    // reach the top, so saturation only guarantees that it never wraps.
    logic [CNT_W-1:0] cnt_inc;
    assign cnt_inc = (cnt_reg == CNT_SAT) ? cnt_reg : cnt_reg + 1'b1;

    // -------------------------------------------------------------------------
    // FSM next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next        = state_reg;
        cnt_next          = cnt_reg;
        mask_next         = mask_reg;
        sw_seq_next       = sw_seq_reg;
        member_reset_next = member_reset_reg;

        case (state_reg)
            ST_SYNC: begin
                if (!sync_chain_reg[SYNC_STAGES-1]) begin
                    state_next = ST_HOLD;
                    cnt_next   = '0;
                end
            end

            ST_HOLD: begin
                if (cnt_reg == HOLD_LAST) begin
                    member_reset_next = member_reset_reg & ~release_onehot;
                    cnt_next          = '0;
                    if (last_release) begin
                        state_next = sw_seq_reg ? ST_RESP : ST_IDLE;
                    end else begin
                        state_next = ST_RELEASE;
                    end
                end else begin
                    cnt_next = cnt_inc;
                end
            end

            ST_RELEASE: begin
                if (cnt_reg == GAP_LAST) begin
                    member_reset_next = member_reset_reg & ~release_onehot;
                    cnt_next          = '0;
                    if (last_release) begin
                        state_next = sw_seq_reg ? ST_RESP : ST_IDLE;
                    end
                end else begin
                    cnt_next = cnt_inc;
                end
            end

            ST_RESP: begin
                if (io_resp_ready) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            end

            ST_IDLE: begin
                if (io_req_valid) begin
                    mask_next   = io_req_bits_mask;
                    sw_seq_next = 1'b1;
                    cnt_next    = '0;
                    // Only masked members re-enter reset. All others were
                    // released earlier and stay low.
                    member_reset_next = member_reset_reg | io_req_bits_mask;
                    state_next = (|io_req_bits_mask) ? ST_HOLD : ST_RESP;
                end
            end

            default: begin
                state_next = ST_SYNC;
                cnt_next   = '0;
            end
        endcase
    end

    // All handshake/status outputs are registered. Their next values are
    // decoded from the next state, so they change on the same edge as the
    // state does.
    always_comb begin
        req_ready_next  = (state_next == ST_IDLE);
        resp_valid_next = (state_next == ST_RESP);
        busy_next       = (state_next != ST_IDLE);
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // An assertion of reset at any point aborts the sequence and drops a
    // pending response. The power-on sequence then runs again from SYNC.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg        <= ST_SYNC;
            cnt_reg          <= '0;
            mask_reg         <= '0;
            sw_seq_reg       <= 1'b0;
            member_reset_reg <= {NUM_MEMBERS{1'b1}};
            req_ready_reg    <= 1'b0;
            resp_valid_reg   <= 1'b0;
            busy_reg         <= 1'b1;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            mask_reg         <= mask_next;
            sw_seq_reg       <= sw_seq_next;
            member_reset_reg <= member_reset_next;
            req_ready_reg    <= req_ready_next;
            resp_valid_reg   <= resp_valid_next;
            busy_reg         <= busy_next;
        end
    end

    assign io_req_ready    = req_ready_reg;
    assign io_resp_valid   = resp_valid_reg;
    assign io_member_reset = member_reset_reg;
    assign io_busy         = busy_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
//
// Self-checking bench for reset_sequencer with default parameters.
// A table of software requests drives the main checks. Each entry lists the
// expected release offset of every member, counted from the accept edge, and
// the offset at which the response appears. Hand-written sequences cover:
//   - power-on timing, with a request held during power-on,
//   - reset abort during RELEASE and during RESP.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

    localparam int N = 4;

    logic         clock;
    logic         reset;
    logic         io_req_valid;
    logic         io_req_ready;
    logic [N-1:0] io_req_bits_mask;
    logic         io_resp_valid;
    logic         io_resp_ready;
    logic [N-1:0] io_member_reset;
    logic         io_busy;

    int n_checks = 0;
    int n_errors = 0;

    reset_sequencer #(
        .SYNC_STAGES(3),
        .NUM_MEMBERS(N),
        .HOLD_CYCLES(16),
        .GAP_CYCLES (4)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .io_req_valid    (io_req_valid),
        .io_req_ready    (io_req_ready),
        .io_req_bits_mask(io_req_bits_mask),
        .io_resp_valid   (io_resp_valid),
        .io_resp_ready   (io_resp_ready),
        .io_member_reset (io_member_reset),
        .io_busy         (io_busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // One software request and its hand-computed schedule.
    // rel[i]  : offset (edges after accept edge t) at which member i drops;
    //           only meaningful for masked members.
    // resp_at : offset at which io_resp_valid is first seen high.
    // stall   : extra cycles io_resp_ready is held low once the response is up.
    typedef struct packed {
        logic [3:0]      mask;
        logic [3:0][7:0] rel;
        logic [7:0]      resp_at;
        logic [7:0]      stall;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] mask,
                                input int r3, input int r2,
                                input int r1, input int r0,
                                input int resp_at, input int stall);
        vec_t v;
        v.mask    = mask;
        v.rel[3]  = 8'(r3);
        v.rel[2]  = 8'(r2);
        v.rel[1]  = 8'(r1);
        v.rel[0]  = 8'(r0);
        v.resp_at = 8'(resp_at);
        v.stall   = 8'(stall);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Power-on. Reset falls at a negedge, so the next posedge is edge 0.
    // Member i should drop at edge 19 + 4*i. Ready should rise at edge 31.
    // With hold_valid set, a 1010 request is held throughout. It must be
    // taken on edge 32, the first edge the block spends in IDLE.
    task automatic power_on(input logic hold_valid);
        logic [3:0] exp_m;
        reset = 1'b1;
        #1;
        check("async_rst_member", 32'(io_member_reset), 32'hF);
        check("async_rst_resp", 32'(io_resp_valid), 32'h0);
        check("async_rst_ready", 32'(io_req_ready), 32'h0);
        check("async_rst_busy", 32'(io_busy), 32'h1);
        @(negedge clock);
        reset            = 1'b0;
        io_req_valid     = hold_valid;
        io_req_bits_mask = 4'b1010;
        io_resp_ready    = 1'b0;
        for (int e = 0; e <= 31; e++) begin
            @(negedge clock);
            for (int i = 0; i < N; i++) exp_m[i] = (e < 19 + 4 * i);
            check($sformatf("po_member_e%0d", e), 32'(io_member_reset), 32'(exp_m));
            check($sformatf("po_ready_e%0d", e), 32'(io_req_ready), 32'(e >= 31));
            check($sformatf("po_busy_e%0d", e), 32'(io_busy), 32'(e < 31));
            check($sformatf("po_resp_e%0d", e), 32'(io_resp_valid), 32'h0);
        end
        @(negedge clock);
        if (hold_valid) begin
            check("po_accept_member", 32'(io_member_reset), 32'hA);
            check("po_accept_ready", 32'(io_req_ready), 32'h0);
            check("po_accept_busy", 32'(io_busy), 32'h1);
            io_req_valid = 1'b0;
            finish_resp();
        end else begin
            check("po_idle_member", 32'(io_member_reset), 32'h0);
            check("po_idle_ready", 32'(io_req_ready), 32'h1);
            check("po_idle_busy", 32'(io_busy), 32'h0);
        end
        $display("txn power_on hold_valid=%0b done", hold_valid);
    endtask

    // Waits (bounded) for a response, then performs the handshake.
    task automatic finish_resp();
        int waited = 0;
        while (io_resp_valid !== 1'b1 && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        check("resp_arrives", 32'(io_resp_valid), 32'h1);
        io_resp_ready = 1'b1;
        @(negedge clock);
        io_resp_ready = 1'b0;
        check("hs_resp_cleared", 32'(io_resp_valid), 32'h0);
        check("hs_ready", 32'(io_req_ready), 32'h1);
        check("hs_busy", 32'(io_busy), 32'h0);
    endtask

    // Issues one request from IDLE and checks it cycle by cycle.
    task automatic run_vec(input vec_t v, input int idx);
        logic [3:0] exp_m;
        check($sformatf("v%0d_idle_ready", idx), 32'(io_req_ready), 32'h1);
        io_req_valid     = 1'b1;
        io_req_bits_mask = v.mask;
        for (int k = 0; k <= int'(v.resp_at); k++) begin
            @(negedge clock);
            io_req_valid = 1'b0;
            for (int i = 0; i < N; i++) exp_m[i] = v.mask[i] && (k < int'(v.rel[i]));
            check($sformatf("v%0d_member_k%0d", idx, k), 32'(io_member_reset), 32'(exp_m));
            check($sformatf("v%0d_resp_k%0d", idx, k), 32'(io_resp_valid),
                  32'(k >= int'(v.resp_at)));
            check($sformatf("v%0d_busy_k%0d", idx, k), 32'(io_busy), 32'h1);
            check($sformatf("v%0d_ready_k%0d", idx, k), 32'(io_req_ready), 32'h0);
        end
        for (int s = 0; s < int'(v.stall); s++) begin
            @(negedge clock);
            check($sformatf("v%0d_stall_resp_s%0d", idx, s), 32'(io_resp_valid), 32'h1);
            check($sformatf("v%0d_stall_ready_s%0d", idx, s), 32'(io_req_ready), 32'h0);
            check($sformatf("v%0d_stall_member_s%0d", idx, s), 32'(io_member_reset), 32'h0);
        end
        io_resp_ready = 1'b1;
        @(negedge clock);
        io_resp_ready = 1'b0;
        check($sformatf("v%0d_done_resp", idx), 32'(io_resp_valid), 32'h0);
        check($sformatf("v%0d_done_ready", idx), 32'(io_req_ready), 32'h1);
        check($sformatf("v%0d_done_busy", idx), 32'(io_busy), 32'h0);
        check($sformatf("v%0d_done_member", idx), 32'(io_member_reset), 32'h0);
        $display("txn request mask=%b resp_at=%0d stall=%0d done", v.mask, v.resp_at, v.stall);
    endtask

    initial begin
        vec_t vecs[7];
        logic [3:0] exp_m;

        //            mask     r3  r2  r1  r0 resp stall
        vecs[0] = mk(4'b1010, 20,  0, 16,  0, 20, 50);
        vecs[1] = mk(4'b0001,  0,  0,  0, 16, 16,  0);
        vecs[2] = mk(4'b1111, 28, 24, 20, 16, 28,  2);
        vecs[3] = mk(4'b0110,  0, 20, 16,  0, 20,  1);
        vecs[4] = mk(4'b1001, 20,  0,  0, 16, 20,  0);
        vecs[5] = mk(4'b0000,  0,  0,  0,  0,  0,  3);
        vecs[6] = mk(4'b1000, 16,  0,  0,  0, 16,  0);

        reset            = 1'b1;
        io_req_valid     = 1'b0;
        io_req_bits_mask = '0;
        io_resp_ready    = 1'b0;

        @(negedge clock);
        power_on(1'b1);

        for (int j = 0; j < 7; j++) begin
            run_vec(vecs[j], j);
        end

        // Abort in RELEASE: a full-mask request, reset applied once member 1
        // has dropped (member 1 drops at k=20; reset comes after k=21).
        io_req_valid     = 1'b1;
        io_req_bits_mask = 4'b1111;
        for (int k = 0; k <= 21; k++) begin
            @(negedge clock);
            io_req_valid = 1'b0;
        end
        for (int i = 0; i < N; i++) exp_m[i] = (21 < 16 + 4 * i);
        check("abort_pre_member", 32'(io_member_reset), 32'(exp_m));
        $display("txn abort during RELEASE");
        power_on(1'b0);

        // Abort in RESP: a zero-mask response is pending when reset hits.
        io_req_valid     = 1'b1;
        io_req_bits_mask = 4'b0000;
        @(negedge clock);
        io_req_valid = 1'b0;
        check("abort_resp_pending", 32'(io_resp_valid), 32'h1);
        check("abort_resp_member", 32'(io_member_reset), 32'h0);
        $display("txn abort during RESP");
        power_on(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
